// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin bitwise logic unit
//
// Purpose:
//   Two requesters share a single bitwise logic unit that performs AND, OR,
//   XOR or NOT A. The unit accepts one operation at a time through a
//   three-state FSM (IDLE -> EXEC -> DONE), so it can start at most one
//   operation every three cycles.
//
//   Timing: the grant is issued in cycle N. The result is computed in N+1,
//   and result, zero and the done pulse are valid in cycle N+2.
//
// Ports:
//   clk            single clock; all state changes on its rising edge
//   reset          asynchronous, active-high reset
//   req0, req1     operation request per requester; held until its gnt is seen
//   op0, op1       opcode per requester: 00 AND, 01 OR, 10 XOR, 11 NOT A
//   a0, b0, a1, b1 operands per requester (WIDTH bits each)
//   gnt0, gnt1     one-cycle acceptance pulse (never both high at once)
//   done0, done1   one-cycle completion pulse to the owning requester
//   result         registered result of the last completed operation
//   zero           high when result is all zeros
//   busy           high while the FSM is in EXEC or DONE

module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;    // requester served most recently
  logic             owner_q, owner_d;  // requester owning the in-flight op
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             any_req;
  logic             win1;
  logic             grant_fire;
  logic [WIDTH-1:0] alu_out;

  // Requester 1 wins if it is the only one asking, or on a tie when
  // requester 0 was the one served last.
  assign any_req = req0 | req1;
  assign win1    = req1 & (~req0 | ~last_q);

  // The grant is decoded from state and requests in the same cycle. State is
  // already IDLE while reset is held, so reset has to be gated in explicitly
  // to keep gnt low during reset.
  assign grant_fire = (state_q == ST_IDLE) & any_req & ~reset;

  always_comb begin
    alu_out = '0;
    case (op_q)
      OP_AND:  alu_out = a_q & b_q;
      OP_OR:   alu_out = a_q | b_q;
      OP_XOR:  alu_out = a_q ^ b_q;
      OP_NOTA: alu_out = ~a_q;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_EXEC;
          owner_d = win1;
          last_d  = win1;
          op_d    = win1 ? op1 : op0;
          a_d     = win1 ? a1  : a0;
          b_d     = win1 ? b1  : b0;
        end
      end
      ST_EXEC: begin
        result_d = alu_out;
        zero_d   = (alu_out == '0);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // The unused encoding falls back to IDLE without producing a pulse.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign gnt0   = grant_fire & ~win1;
  assign gnt1   = grant_fire &  win1;
  assign done0  = (state_q == ST_DONE) & ~owner_q;
  assign done1  = (state_q == ST_DONE) &  owner_q;
  assign busy   = (state_q == ST_EXEC) | (state_q == ST_DONE);
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter

module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] result;
  logic       zero, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_result;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [1:0] o0;
    logic [1:0] o1;
    logic [7:0] va0;
    logic [7:0] vb0;
    logic [7:0] va1;
    logic [7:0] vb1;
    logic       eg0;
    logic       eg1;
    logic [7:0] eres;
    logic       ezero;
  } vec_t;

  vec_t vecs[9];

  logic_unit_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mutual exclusion of the grant pulses and of the done pulses, every cycle.
  always @(negedge clk) begin
    checks++;
    if ((gnt0 & gnt1) || (done0 & done1)) begin
      errors++;
      $display("FAIL exclusive: gnt=%b%b done=%b%b expected no pair high", gnt0, gnt1, done0, done1);
    end
  end

  // One full transaction starting from IDLE: grant, exec, done.
  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    req0 = v.r0; req1 = v.r1; op0 = v.o0; op1 = v.o1;
    a0 = v.va0; b0 = v.vb0; a1 = v.va1; b1 = v.vb1;
    @(negedge clk);
    chk($sformatf("v%0d gnt0", idx), 32'(gnt0), 32'(v.eg0));
    chk($sformatf("v%0d gnt1", idx), 32'(gnt1), 32'(v.eg1));
    chk($sformatf("v%0d busy_idle", idx), 32'(busy), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h5A; b0 = 8'h5A; a1 = 8'h5A; b1 = 8'h5A;
    @(negedge clk);
    chk($sformatf("v%0d busy_exec", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d done_exec", idx), 32'({done0, done1}), 32'd0);
    chk($sformatf("v%0d result_hold", idx), 32'(result), 32'(prev_result));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d done0", idx), 32'(done0), 32'(v.eg0));
    chk($sformatf("v%0d done1", idx), 32'(done1), 32'(v.eg1));
    chk($sformatf("v%0d result", idx), 32'(result), 32'(v.eres));
    chk($sformatf("v%0d zero", idx), 32'(zero), 32'(v.ezero));
    chk($sformatf("v%0d busy_done", idx), 32'(busy), 32'd1);
    prev_result = v.eres;
  endtask

  initial begin
    // Pointer history: it starts at 1, so the first tie goes to requester 0.
    //              r0    r1    o0     o1     a0     b0     a1     b1     g0    g1    res    zero
    vecs[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 8'hFF, 8'hA9, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA9, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 2'b00, 2'b01, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'b00, 2'b01, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hFC, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'b10, 2'b00, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 8'hCC, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 2'b11, 8'h00, 8'h00, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h0F, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 2'b11, 8'h00, 8'h00, 8'hFF, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 2'b01, 2'b10, 8'h00, 8'h00, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 2'b01, 2'b10, 8'h00, 8'h00, 8'hAA, 8'h55, 1'b0, 1'b1, 8'hFF, 1'b0};

    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    prev_result = 8'h00;

    // Reset state, with a request held to confirm that gnt stays low.
    repeat (2) @(negedge clk);
    chk("rst gnt0", 32'(gnt0), 32'd0);
    chk("rst gnt1", 32'(gnt1), 32'd0);
    chk("rst done", 32'({done0, done1}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", 32'(result), 32'h00);
    chk("rst zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Tie held continuously after a fresh reset: expect grants 0,1,0 three cycles apart.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; op0 = 2'b00; op1 = 2'b00;
    a0 = 8'h0F; b0 = 8'hFF; a1 = 8'hF0; b1 = 8'hFF;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("tie c%0d gnt0", c), 32'(gnt0), 32'((c == 0) || (c == 6)));
      chk($sformatf("tie c%0d gnt1", c), 32'(gnt1), 32'(c == 3));
      chk($sformatf("tie c%0d done0", c), 32'(done0), 32'((c == 2) || (c == 8)));
      chk($sformatf("tie c%0d done1", c), 32'(done1), 32'(c == 5));
      if (c == 2 || c == 8) chk($sformatf("tie c%0d result", c), 32'(result), 32'h0F);
      if (c == 5) chk("tie c5 result", 32'(result), 32'hF0);
    end

    // Operand changes after the grant must not affect the in-flight result.
    @(posedge clk); #1;
    req1 = 1'b0; req0 = 1'b1; op0 = 2'b00; a0 = 8'hFF; b0 = 8'hFF;
    @(negedge clk);
    chk("hold gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; a0 = 8'h00;
    @(negedge clk);
    chk("hold busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold done0", 32'(done0), 32'd1);
    chk("hold result", 32'(result), 32'hFF);
    chk("hold zero", 32'(zero), 32'd0);

    // Reset during EXEC aborts the operation without a done pulse.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 2'b00; a0 = 8'hFF; b0 = 8'hFF;
    @(negedge clk);
    chk("abort gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", 32'(result), 32'h00);
    chk("abort zero", 32'(zero), 32'd1);
    chk("abort done", 32'({done0, done1}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort c%0d done", c), 32'({done0, done1}), 32'd0);
      chk($sformatf("abort c%0d busy", c), 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 2'b01; a0 = 8'h12; b0 = 8'h40;
    @(negedge clk);
    chk("restart gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart done0", 32'(done0), 32'd1);
    chk("restart result", 32'(result), 32'h52);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
